// File: rtl/vram_bus_arbiter_if.sv
// Signal bundle between the VRAM requesters (A = VDP, B = aux master),
// the arbiter and the SDRAM controller command bus.
interface vram_bus_arbiter_if;
    logic        initial_busy;

    logic [17:0] a_address;
    logic        a_valid;
    logic        a_write;
    logic [31:0] a_wdata;
    logic [3:0]  a_wdata_mask;
    logic        a_refresh;
    logic        a_ready;
    logic [31:0] a_rdata;
    logic        a_rdata_en;

    logic [17:0] b_address;
    logic        b_valid;
    logic        b_write;
    logic [31:0] b_wdata;
    logic [3:0]  b_wdata_mask;
    logic        b_ready;
    logic [31:0] b_rdata;
    logic        b_rdata_en;

    logic [17:0] m_address;
    logic        m_valid;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [3:0]  m_wdata_mask;
    logic        m_refresh;
    logic [31:0] m_rdata;
    logic        m_rdata_en;

    logic        rd_timeout_err;

    // Arbiter side
    modport slave (
        input  initial_busy,
        input  a_address, a_valid, a_write, a_wdata, a_wdata_mask, a_refresh,
        output a_ready, a_rdata, a_rdata_en,
        input  b_address, b_valid, b_write, b_wdata, b_wdata_mask,
        output b_ready, b_rdata, b_rdata_en,
        output m_address, m_valid, m_write, m_wdata, m_wdata_mask, m_refresh,
        input  m_rdata, m_rdata_en,
        output rd_timeout_err
    );

    // Requester / SDRAM controller side
    modport master (
        output initial_busy,
        output a_address, a_valid, a_write, a_wdata, a_wdata_mask, a_refresh,
        input  a_ready, a_rdata, a_rdata_en,
        output b_address, b_valid, b_write, b_wdata, b_wdata_mask,
        input  b_ready, b_rdata, b_rdata_en,
        input  m_address, m_valid, m_write, m_wdata, m_wdata_mask, m_refresh,
        output m_rdata, m_rdata_en,
        input  rd_timeout_err
    );
endinterface

// File: rtl/vram_bus_arbiter.sv
// Two-port arbiter for the VRAM/SDRAM word bus. One transaction in flight,
// refresh forwarded with priority, A preferred but B forced in after
// A_STREAK_MAX consecutive A wins while B waits.
module vram_bus_arbiter #(
    parameter int A_STREAK_MAX = 4,
    parameter int WR_GAP       = 2,
    parameter int REF_GAP      = 8,
    parameter int RD_TIMEOUT   = 64
) (
    input logic              clk,
    input logic              reset_n,
    vram_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_RD, WAIT_WR, REFRESH
    } state_t;

    state_t      state_q;
    logic        owner_b_q;
    logic [3:0]  streak_q, streak_d;
    logic        ref_pend_q, ref_pend_d;
    logic        busy_q;
    logic [7:0]  cnt_q;
    logic        err_q;

    logic [17:0] m_address_q;
    logic        m_write_q;
    logic [31:0] m_wdata_q;
    logic [3:0]  m_mask_q;
    logic        m_valid_q, m_refresh_q, a_ready_q, b_ready_q;

    logic        idle_go, ref_take, grant_any, grant_b, rd_done, rd_tmo;

    // initial_busy is registered, so a falling edge releases the first
    // command two cycles later; busy_q resets high so nothing issues before
    // the controller has been seen idle at least once.
    assign idle_go   = (state_q == IDLE) && !busy_q;
    // A refresh pulse coincident with a request is served first.
    assign ref_take  = idle_go && (ref_pend_q || bus.a_refresh);
    assign grant_b   = bus.b_valid && (!bus.a_valid || (streak_q == 4'(A_STREAK_MAX)));
    assign grant_any = idle_go && !ref_take && (bus.a_valid || bus.b_valid);
    assign rd_done   = (state_q == WAIT_RD) && bus.m_rdata_en;
    assign rd_tmo    = (state_q == WAIT_RD) && !bus.m_rdata_en && (cnt_q == 8'(RD_TIMEOUT - 1));

    // Streak and refresh-pending next state
    always_comb begin
        streak_d   = streak_q;
        ref_pend_d = ref_take ? 1'b0 : (ref_pend_q || bus.a_refresh);
        if (grant_any) begin
            if (grant_b)
                streak_d = 4'd0;
            else if (bus.b_valid)
                streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
            else
                streak_d = 4'd0;
        end
    end

    // Arbitration FSM with registered strobes and command fields
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_b_q   <= 1'b0;
            streak_q    <= 4'd0;
            ref_pend_q  <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            m_address_q <= '0;
            m_write_q   <= 1'b0;
            m_wdata_q   <= '0;
            m_mask_q    <= '0;
            m_valid_q   <= 1'b0;
            m_refresh_q <= 1'b0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
        end else begin
            busy_q      <= bus.initial_busy;
            streak_q    <= streak_d;
            ref_pend_q  <= ref_pend_d;
            m_valid_q   <= 1'b0;
            m_refresh_q <= 1'b0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            if (rd_tmo)
                err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ref_take) begin
                        m_refresh_q <= 1'b1;
                        cnt_q       <= 8'd0;
                        state_q     <= REFRESH;
                    end else if (grant_any) begin
                        m_address_q <= grant_b ? bus.b_address    : bus.a_address;
                        m_write_q   <= grant_b ? bus.b_write      : bus.a_write;
                        m_wdata_q   <= grant_b ? bus.b_wdata      : bus.a_wdata;
                        m_mask_q    <= grant_b ? bus.b_wdata_mask : bus.a_wdata_mask;
                        owner_b_q   <= grant_b;
                        m_valid_q   <= 1'b1;
                        a_ready_q   <= !grant_b;
                        b_ready_q   <= grant_b;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= 8'd0;
                    if (!m_write_q)
                        state_q <= WAIT_RD;
                    else if (WR_GAP == 0)
                        state_q <= IDLE;
                    else
                        state_q <= WAIT_WR;
                end
                WAIT_WR: begin
                    if (cnt_q == 8'(WR_GAP - 1))
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q + 8'd1;
                end
                WAIT_RD: begin
                    if (rd_done || rd_tmo)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q + 8'd1;
                end
                REFRESH: begin
                    if (cnt_q == 8'(REF_GAP - 1))
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_address    = m_address_q;
    assign bus.m_write      = m_write_q;
    assign bus.m_wdata      = m_wdata_q;
    assign bus.m_wdata_mask = m_mask_q;
    assign bus.m_valid      = m_valid_q;
    assign bus.m_refresh    = m_refresh_q;
    assign bus.a_ready      = a_ready_q;
    assign bus.b_ready      = b_ready_q;

    // Read return is combinational from the SDRAM; a timeout substitutes
    // all-ones data for the owner so the requester never hangs.
    assign bus.a_rdata_en   = (rd_done || rd_tmo) && !owner_b_q;
    assign bus.b_rdata_en   = (rd_done || rd_tmo) &&  owner_b_q;
    assign bus.a_rdata      = (rd_tmo && !owner_b_q) ? 32'hFFFF_FFFF : bus.m_rdata;
    assign bus.b_rdata      = (rd_tmo &&  owner_b_q) ? 32'hFFFF_FFFF : bus.m_rdata;
    assign bus.rd_timeout_err = err_q || rd_tmo;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench for vram_bus_arbiter with default parameters.
module tb_vram_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    vram_bus_arbiter_if bus();

    vram_bus_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        string seq;
        string exp_seq;
        int    ng;
        int    nref;
        int    ref_at;
        logic  flag;

        reset_n               = 1'b0;
        bus.initial_busy      = 1'b0;
        bus.a_address         = '0;
        bus.a_valid           = 1'b0;
        bus.a_write           = 1'b0;
        bus.a_wdata           = '0;
        bus.a_wdata_mask      = '0;
        bus.a_refresh         = 1'b0;
        bus.b_address         = '0;
        bus.b_valid           = 1'b0;
        bus.b_write           = 1'b0;
        bus.b_wdata           = '0;
        bus.b_wdata_mask      = '0;
        bus.m_rdata           = '0;
        bus.m_rdata_en        = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_refresh", bus.m_refresh, 0);
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_m_address", bus.m_address, 0);
        chk("rst_m_write", bus.m_write, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_m_mask", bus.m_wdata_mask, 0);
        chk("rst_err", bus.rd_timeout_err, 0);
        reset_n = 1'b1;
        tick();

        // single A read: request cycle 0, issue cycle 1, data cycle 5
        bus.a_valid   = 1'b1;
        bus.a_write   = 1'b0;
        bus.a_address = 18'h00100;
        tick();
        chk("rd_m_valid", bus.m_valid, 1);
        chk("rd_a_ready", bus.a_ready, 1);
        chk("rd_b_ready", bus.b_ready, 0);
        chk("rd_m_address", bus.m_address, 18'h00100);
        chk("rd_m_write", bus.m_write, 0);
        bus.a_valid = 1'b0;
        tick();
        chk("rd_m_valid_drop", bus.m_valid, 0);
        tick(); tick(); tick();
        bus.m_rdata    = 32'h12345678;
        bus.m_rdata_en = 1'b1;
        #1;
        chk("rd_a_rdata_en", bus.a_rdata_en, 1);
        chk("rd_a_rdata", bus.a_rdata, 32'h12345678);
        chk("rd_b_rdata_en", bus.b_rdata_en, 0);
        chk("rd_b_rdata", bus.b_rdata, 32'h12345678);
        tick();
        bus.m_rdata_en = 1'b0;
        #1;
        chk("rd_a_rdata_en_end", bus.a_rdata_en, 0);

        // fairness: both requesting writes continuously
        bus.a_valid = 1'b1; bus.a_write = 1'b1; bus.a_address = 18'h00AAA;
        bus.b_valid = 1'b1; bus.b_write = 1'b1; bus.b_address = 18'h00BBB;
        seq = "";
        exp_seq = "AAAABAAAAB";
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            tick();
            if (bus.a_ready) begin seq = {seq, "A"}; ng++; end
            else if (bus.b_ready) begin seq = {seq, "B"}; ng++; end
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        chk("fair_count", ng, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("fair_grant%0d", i), seq[i], exp_seq[i]);
        tick(); tick(); tick();

        // refresh collides with an A read request in IDLE
        bus.a_refresh = 1'b1;
        bus.a_valid   = 1'b1;
        bus.a_write   = 1'b0;
        bus.a_address = 18'h00200;
        tick();
        bus.a_refresh = 1'b0;
        chk("refc_m_refresh", bus.m_refresh, 1);
        chk("refc_m_valid", bus.m_valid, 0);
        flag = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            if (bus.m_valid || bus.a_ready || bus.m_refresh) flag = 1'b1;
        end
        chk("refc_quiet", flag, 0);
        tick();
        chk("refc_m_valid_late", bus.m_valid, 1);
        chk("refc_a_ready_late", bus.a_ready, 1);
        chk("refc_addr", bus.m_address, 18'h00200);
        bus.a_valid = 1'b0;
        // two refresh pulses while waiting for read data merge into one
        nref = 0;
        ref_at = -1;
        bus.m_rdata = 32'hCAFEF00D;
        for (int k = 11; k <= 30; k++) begin
            tick();
            bus.a_refresh  = (k == 12 || k == 14);
            bus.m_rdata_en = (k == 16);
            #1;
            if (k == 16) chk("refc_rdata_en", bus.a_rdata_en, 1);
            if (bus.m_refresh) begin nref++; ref_at = k; end
        end
        bus.a_refresh  = 1'b0;
        bus.m_rdata_en = 1'b0;
        chk("refm_count", nref, 1);
        chk("refm_cycle", ref_at, 18);

        // initial_busy blocks a pending B write for 100 cycles
        bus.initial_busy = 1'b1;
        tick();
        bus.b_valid      = 1'b1;
        bus.b_write      = 1'b1;
        bus.b_address    = 18'h3FFFF;
        bus.b_wdata      = 32'hDEADBEEF;
        bus.b_wdata_mask = 4'hA;
        flag = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.m_valid || bus.b_ready) flag = 1'b1;
        end
        chk("busy_no_cmd", flag, 0);
        bus.initial_busy = 1'b0;
        #1;
        chk("busy_f0_ready", bus.b_ready, 0);
        tick();
        chk("busy_f1_ready", bus.b_ready, 0);
        tick();
        chk("busy_f2_ready", bus.b_ready, 1);
        chk("busy_f2_valid", bus.m_valid, 1);
        chk("busy_addr", bus.m_address, 18'h3FFFF);
        chk("busy_write", bus.m_write, 1);
        chk("busy_wdata", bus.m_wdata, 32'hDEADBEEF);
        chk("busy_mask", bus.m_wdata_mask, 4'hA);
        bus.b_valid = 1'b0;
        tick();
        chk("hold_valid", bus.m_valid, 0);
        chk("hold_addr", bus.m_address, 18'h3FFFF);
        tick(); tick();

        // B read timeout
        bus.b_valid   = 1'b1;
        bus.b_write   = 1'b0;
        bus.b_address = 18'h01234;
        bus.m_rdata   = 32'h0BADF00D;
        tick();
        chk("tmo_b_ready", bus.b_ready, 1);
        chk("tmo_addr", bus.m_address, 18'h01234);
        bus.b_valid = 1'b0;
        flag = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (bus.b_rdata_en || bus.a_rdata_en || bus.rd_timeout_err) flag = 1'b1;
        end
        chk("tmo_early", flag, 0);
        tick();
        chk("tmo_b_rdata_en", bus.b_rdata_en, 1);
        chk("tmo_b_rdata", bus.b_rdata, 32'hFFFFFFFF);
        chk("tmo_a_rdata_en", bus.a_rdata_en, 0);
        chk("tmo_a_rdata", bus.a_rdata, 32'h0BADF00D);
        chk("tmo_err", bus.rd_timeout_err, 1);
        tick();
        chk("tmo_b_rdata_en_end", bus.b_rdata_en, 0);
        chk("tmo_err_sticky", bus.rd_timeout_err, 1);
        // stray read data in IDLE is ignored
        bus.m_rdata_en = 1'b1;
        #1;
        chk("stray_a", bus.a_rdata_en, 0);
        chk("stray_b", bus.b_rdata_en, 0);
        tick();
        bus.m_rdata_en = 1'b0;

        // reset during WAIT_RD
        bus.a_valid   = 1'b1;
        bus.a_write   = 1'b0;
        bus.a_address = 18'h00055;
        tick();
        chk("rstrd_a_ready", bus.a_ready, 1);
        chk("rstrd_err_kept", bus.rd_timeout_err, 1);
        bus.a_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("rstrd_m_valid", bus.m_valid, 0);
        chk("rstrd_m_refresh", bus.m_refresh, 0);
        chk("rstrd_a_ready0", bus.a_ready, 0);
        chk("rstrd_b_ready0", bus.b_ready, 0);
        chk("rstrd_m_address", bus.m_address, 0);
        chk("rstrd_err", bus.rd_timeout_err, 0);
        reset_n = 1'b1;
        tick();
        bus.m_rdata_en = 1'b1;
        #1;
        chk("rstrd_late_a", bus.a_rdata_en, 0);
        chk("rstrd_late_b", bus.b_rdata_en, 0);
        tick();
        bus.m_rdata_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
